// File: rtl/instr_queue_if.sv
// Fetch/decode handshake bundle for the instruction queue.
interface instr_queue_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_instr;
  logic [PC_W-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_instr;
  logic [PC_W-1:0]  out_pc;
  logic [CntW-1:0]  count;

  // Queue side.
  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, count
  );

  // Fetch/decode (or bench) side.
  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, count
  );
endinterface

// File: rtl/instr_queue.sv
// DEPTH-entry instruction buffer between fetch and decode, with PC tag and flush.
module instr_queue #(
  parameter int unsigned     WIDTH       = 32,
  parameter int unsigned     PC_W        = 32,
  parameter int unsigned     DEPTH       = 4,
  parameter logic [WIDTH-1:0] EMPTY_INSTR = '0
) (
  input logic          clk,
  input logic          rst_n,
  instr_queue_if.slave bus
);
  localparam int unsigned CntW    = $clog2(DEPTH + 1);
  localparam int unsigned PtrW    = $clog2(DEPTH);
  localparam logic [CntW-1:0] Full    = CntW'(DEPTH);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  logic [PC_W+WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  push, pop;
  logic                  not_empty;

  // Handshake qualification; flush suppresses both sides.
  always_comb begin
    not_empty = (count_q != '0);
    push      = bus.in_valid & (count_q != Full) & ~bus.flush;
    pop       = not_empty & bus.out_ready & ~bus.flush;
  end

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.in_pc, bus.in_instr};
  end

  // Head read is combinational; empty queue presents a NOP with PC 0.
  always_comb begin
    bus.in_ready  = (count_q != Full);
    bus.out_valid = not_empty;
    bus.count     = count_q;
    bus.out_instr = EMPTY_INSTR;
    bus.out_pc    = '0;
    if (not_empty) begin
      bus.out_instr = mem_q[rd_ptr_q][WIDTH-1:0];
      bus.out_pc    = mem_q[rd_ptr_q][PC_W+WIDTH-1:WIDTH];
    end
  end
endmodule
